id_stage: RTL and testbench

- Decode stage directly downstream of instruction fetch. Consumes the fetched pc/inst pair and holds it in an IF/ID latch.
- Decodes the instruction, reads a 32-entry register file, generates imm32, and drives the ID/EX latch.
- Feeds fetch back with its stall, ecall, jmp, jump base and imm32 controls.
- Contains the load-use hazard detector and the ecall wait FSM.

---
 rtl/id_stage.sv | 255 +++++++++++++++++++++++++
 tb/tb_id_stage.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Decode stage: IF/ID latch, RV32I decode, 32x32 register file, load-use hazard and ecall wait FSM.
// Define REGFILE_BYPASS_EN for a write-first register read instead of a write-back stall.
module id_stage #(
  parameter logic [31:0] NOP_INST      = 32'h0000_0013,
  parameter int unsigned ECALL_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        io_done,
  output logic        stall,
  output logic        ecall,
  output logic        jmp,
  output logic [31:0] jmp_base,
  output logic [31:0] imm32,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rs1,
  output logic [31:0] ex_rs2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd_o,
  output logic [11:0] ex_ctrl,
  output logic        illegal
);
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpReg    = 7'b0110011;
  localparam logic [6:0] OpSystem = 7'b1110011;
  localparam logic [31:0] EcallInst = 32'h0000_0073;

  typedef enum logic [1:0] {StRun, StEcallWait, StResume} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] if_pc_q, if_pc_d, if_inst_q, if_inst_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [31:0] ex_pc_q, ex_pc_d, ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_imm_q, ex_imm_d;
  logic [4:0]  ex_dst_q, ex_dst_d;
  logic [11:0] ex_ctrl_q, ex_ctrl_d;

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  funct3;
  logic [31:0] imm, rs1_data, rs2_data;
  logic        rs1_used, rs2_used, legal, is_jump_op;
  logic        reg_write, mem_read, mem_write, alu_src, branch, jump, use_f3, f7b5, is_lui, is_auipc;
  logic [11:0] ctrl;
  logic        wb_haz, haz, ecall_entry, jmp_int, illegal_int, stall_int;

  assign opcode = if_inst_q[6:0];
  assign rd     = if_inst_q[11:7];
  assign funct3 = if_inst_q[14:12];
  assign rs1    = if_inst_q[19:15];
  assign rs2    = if_inst_q[24:20];

  always_comb begin
    imm        = '0;
    rs1_used   = 1'b0;
    rs2_used   = 1'b0;
    legal      = 1'b1;
    is_jump_op = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;
    use_f3     = 1'b0;
    f7b5       = 1'b0;
    is_lui     = 1'b0;
    is_auipc   = 1'b0;
    case (opcode)
      OpLui, OpAuipc: begin
        imm       = {if_inst_q[31:12], 12'b0};
        reg_write = 1'b1;
        alu_src   = 1'b1;
        is_lui    = (opcode == OpLui);
        is_auipc  = (opcode == OpAuipc);
      end
      OpJal: begin
        imm = {{11{if_inst_q[31]}}, if_inst_q[31], if_inst_q[19:12], if_inst_q[20],
               if_inst_q[30:21], 1'b0};
        is_jump_op = 1'b1;
        reg_write  = 1'b1;
        jump       = 1'b1;
      end
      OpJalr, OpLoad, OpImm: begin
        imm       = {{20{if_inst_q[31]}}, if_inst_q[31:20]};
        rs1_used  = 1'b1;
        reg_write = 1'b1;
        alu_src   = 1'b1;
        use_f3    = 1'b1;
        mem_read  = (opcode == OpLoad);
        is_jump_op = (opcode == OpJalr);
        jump      = (opcode == OpJalr);
        // Only srai carries a funct7 bit; other OP-IMM encodings use inst[30] as immediate.
        f7b5      = (opcode == OpImm) && (funct3 == 3'b101) && if_inst_q[30];
      end
      OpSystem: imm = {{20{if_inst_q[31]}}, if_inst_q[31:20]};
      OpStore: begin
        imm       = {{20{if_inst_q[31]}}, if_inst_q[31:25], if_inst_q[11:7]};
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        mem_write = 1'b1;
        alu_src   = 1'b1;
        use_f3    = 1'b1;
      end
      OpBranch: begin
        imm = {{19{if_inst_q[31]}}, if_inst_q[31], if_inst_q[7], if_inst_q[30:25],
               if_inst_q[11:8], 1'b0};
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        branch   = 1'b1;
        use_f3   = 1'b1;
      end
      OpReg: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        reg_write = 1'b1;
        use_f3    = 1'b1;
        f7b5      = if_inst_q[30];
      end
      default: legal = 1'b0;
    endcase
  end

  assign ctrl = {reg_write, mem_read, mem_write, alu_src, branch, jump,
                 use_f3 ? funct3 : 3'b000, f7b5, is_lui, is_auipc};

`ifdef REGFILE_BYPASS_EN
  assign rs1_data = (rs1 == 5'd0) ? '0 : (wb_en && wb_rd == rs1) ? wb_data : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : (wb_en && wb_rd == rs2) ? wb_data : rf_q[rs2];
  assign wb_haz   = 1'b0;
`else
  assign rs1_data = (rs1 == 5'd0) ? '0 : rf_q[rs1];
  assign rs2_data = (rs2 == 5'd0) ? '0 : rf_q[rs2];
  assign wb_haz   = wb_en && (wb_rd != 5'd0) &&
                    ((wb_rd == rs1 && rs1_used) || (wb_rd == rs2 && rs2_used));
`endif

  assign haz = (ex_mem_read && (ex_rd != 5'd0) &&
                ((ex_rd == rs1 && rs1_used) || (ex_rd == rs2 && rs2_used))) || wb_haz;
  assign ecall_entry = (state_q == StRun) && (if_inst_q == EcallInst) && !flush;
  assign jmp_int     = (state_q == StRun) && is_jump_op && !haz && !flush;
  assign illegal_int = (state_q == StRun) && !legal && !flush;
  assign stall_int   = (state_q == StEcallWait) || ecall_entry ||
                       ((state_q == StRun) && haz && !flush);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    ex_pc_d   = '0;
    ex_rs1_d  = '0;
    ex_rs2_d  = '0;
    ex_imm_d  = '0;
    ex_dst_d  = '0;
    ex_ctrl_d = '0;
    rf_d      = rf_q;
    if (wb_en && wb_rd != 5'd0) rf_d[wb_rd] = wb_data;

    unique case (state_q)
      StRun: begin
        if (ecall_entry) begin
          state_d = StEcallWait;
          cnt_d   = '0;
        end
      end
      StEcallWait: begin
        if (io_done || (ECALL_TIMEOUT != 0 && cnt_q == 32'(ECALL_TIMEOUT - 1))) begin
          state_d = StResume;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StResume: state_d = StRun;
      default:  state_d = StRun;
    endcase

    // ID/EX defaults to a bubble; only a clean advance of a legal instruction issues.
    if (flush || state_q == StResume) begin
      if_pc_d   = '0;
      if_inst_d = NOP_INST;
    end else if (state_q == StEcallWait || ecall_entry || haz) begin
      if_pc_d   = if_pc_q;
    end else begin
      if_pc_d   = jmp_int ? '0 : pc_in;
      if_inst_d = jmp_int ? NOP_INST : inst_in;
      if (legal) begin
        ex_pc_d   = if_pc_q;
        ex_rs1_d  = rs1_data;
        ex_rs2_d  = rs2_data;
        ex_imm_d  = imm;
        ex_dst_d  = reg_write ? rd : 5'd0;
        ex_ctrl_d = ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StRun;
      cnt_q     <= '0;
      if_pc_q   <= '0;
      if_inst_q <= NOP_INST;
      ex_pc_q   <= '0;
      ex_rs1_q  <= '0;
      ex_rs2_q  <= '0;
      ex_imm_q  <= '0;
      ex_dst_q  <= '0;
      ex_ctrl_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      ex_pc_q   <= ex_pc_d;
      ex_rs1_q  <= ex_rs1_d;
      ex_rs2_q  <= ex_rs2_d;
      ex_imm_q  <= ex_imm_d;
      ex_dst_q  <= ex_dst_d;
      ex_ctrl_q <= ex_ctrl_d;
      rf_q      <= rf_d;
    end
  end

  assign stall    = rst & stall_int;
  assign ecall    = rst & (state_q == StEcallWait);
  assign jmp      = rst & jmp_int;
  assign illegal  = rst & illegal_int;
  assign imm32    = rst ? imm : '0;
  assign jmp_base = !rst ? '0 : (opcode == OpJalr) ? rs1_data : if_pc_q;
  assign ex_pc    = rst ? ex_pc_q : '0;
  assign ex_rs1   = rst ? ex_rs1_q : '0;
  assign ex_rs2   = rst ? ex_rs2_q : '0;
  assign ex_imm   = rst ? ex_imm_q : '0;
  assign ex_rd_o  = rst ? ex_dst_q : '0;
  assign ex_ctrl  = rst ? ex_ctrl_q : '0;
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: format-level behavioural model checked every negedge, plus directed
// literal expectations on the main scenarios.
module tb_id_stage;
  localparam logic [31:0] NOP   = 32'h0000_0013;
  localparam int unsigned TMO   = 0;
  localparam logic [31:0] ADDI5 = 32'h0050_0093;
  localparam logic [31:0] ADD6  = 32'h0012_8333;
  localparam logic [31:0] ADD4  = 32'h0001_8233;
  localparam logic [31:0] JALR8 = 32'h0081_00E7;
  localparam logic [31:0] JAL16 = 32'h0100_00EF;
  localparam logic [31:0] BEQM4 = 32'hFE20_8EE3;
  localparam logic [31:0] SWM12 = 32'hFE20_AA23;
  localparam logic [31:0] LUI7  = 32'hABCD_E3B7;
  localparam logic [31:0] BAD   = 32'h0000_007F;
  localparam logic [31:0] ECALL = 32'h0000_0073;
  localparam int SRun = 0, SWait = 1, SRes = 2;

  typedef enum int {FR, FI, FS, FB, FU, FJ, FX} fmt_e;

  logic        clk = 1'b0;
  logic        rst, flush, ex_mem_read, wb_en, io_done;
  logic [31:0] pc_in, inst_in, wb_data;
  logic [4:0]  ex_rd, wb_rd;
  logic        stall, ecall, jmp, illegal;
  logic [31:0] jmp_base, imm32, ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [4:0]  ex_rd_o;
  logic [11:0] ex_ctrl;

  int checks = 0;
  int errors = 0;

  id_stage #(.NOP_INST(NOP), .ECALL_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .inst_in(inst_in), .flush(flush),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .wb_en(wb_en), .wb_rd(wb_rd),
    .wb_data(wb_data), .io_done(io_done), .stall(stall), .ecall(ecall), .jmp(jmp),
    .jmp_base(jmp_base), .imm32(imm32), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_imm(ex_imm), .ex_rd_o(ex_rd_o), .ex_ctrl(ex_ctrl), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state (current and next).
  logic [31:0] m_pc, m_inst, m_ex_pc, m_ex_rs1, m_ex_rs2, m_ex_imm;
  logic [31:0] n_pc, n_inst, n_ex_pc, n_ex_rs1, n_ex_rs2, n_ex_imm;
  logic [31:0] m_rf [32];
  logic [31:0] n_rf [32];
  logic [4:0]  m_ex_rd, n_ex_rd;
  logic [11:0] m_ex_ctrl, n_ex_ctrl;
  int          m_st, n_st;
  int unsigned m_cnt, n_cnt;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      7'b0110011:                                    return FR;
      7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: return FI;
      7'b0100011:                                    return FS;
      7'b1100011:                                    return FB;
      7'b0110111, 7'b0010111:                        return FU;
      7'b1101111:                                    return FJ;
      default:                                       return FX;
    endcase
  endfunction

  // Sign-extend an n-bit field by subtracting 2^n when its top bit is set.
  function automatic logic [31:0] sx(input logic [31:0] v, input int n);
    if (v[n-1]) return v - (32'd1 << n);
    return v;
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] i);
    case (fmt_of(i[6:0]))
      FI: return sx({20'b0, i[31:20]}, 12);
      FS: return sx({20'b0, i[31:25], i[11:7]}, 12);
      FB: return sx({19'b0, i[31], i[7], i[30:25], i[11:8], 1'b0}, 13);
      FU: return {i[31:12], 12'b0};
      FJ: return sx({11'b0, i[31], i[19:12], i[20], i[30:21], 1'b0}, 21);
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit sys(input logic [31:0] i);
    return i[6:0] == 7'b1110011;
  endfunction

  function automatic bit uses_rs1(input logic [31:0] i);
    fmt_e f = fmt_of(i[6:0]);
    return (f == FR || f == FI || f == FS || f == FB) && !sys(i);
  endfunction

  function automatic bit uses_rs2(input logic [31:0] i);
    fmt_e f = fmt_of(i[6:0]);
    return f == FR || f == FS || f == FB;
  endfunction

  function automatic logic [11:0] ctrl_of(input logic [31:0] i);
    fmt_e f = fmt_of(i[6:0]);
    bit rw = (f == FR || f == FU || f == FJ || f == FI) && !sys(i);
    bit mr = i[6:0] == 7'b0000011;
    bit mw = i[6:0] == 7'b0100011;
    bit as = (f == FI && !sys(i)) || f == FS || f == FU;
    bit br = f == FB;
    bit jp = f == FJ || i[6:0] == 7'b1100111;
    logic [2:0] f3 = ((f == FR || f == FI || f == FS || f == FB) && !sys(i)) ? i[14:12] : 3'b0;
    bit f7 = (i[6:0] == 7'b0110011) ? i[30] :
             (i[6:0] == 7'b0010011 && i[14:12] == 3'b101) ? i[30] : 1'b0;
    return {rw, mr, mw, as, br, jp, f3, f7, i[6:0] == 7'b0110111, i[6:0] == 7'b0010111};
  endfunction

  function automatic logic [31:0] rd_reg(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && wb_rd == r) return wb_data;
`endif
    return m_rf[r];
  endfunction

  logic [31:0] e_base, e_imm;
  logic        e_stall, e_ecall, e_jmp, e_ill, hz, is_ec, run;
  logic [4:0]  r1, r2;

  always @(negedge clk) begin
    if (!rst) begin
      {e_stall, e_ecall, e_jmp, e_ill} = '0;
      e_base = '0;
      e_imm  = '0;
      cmp("ex_pc", ex_pc, 0);
      cmp("ex_rs1", ex_rs1, 0);
      cmp("ex_rs2", ex_rs2, 0);
      cmp("ex_imm", ex_imm, 0);
      cmp("ex_rd_o", ex_rd_o, 0);
      cmp("ex_ctrl", ex_ctrl, 0);
      n_pc = '0; n_inst = NOP; n_st = SRun; n_cnt = 0;
      n_ex_pc = '0; n_ex_rs1 = '0; n_ex_rs2 = '0; n_ex_imm = '0; n_ex_rd = '0; n_ex_ctrl = '0;
      for (int k = 0; k < 32; k++) n_rf[k] = '0;
    end else begin
      r1 = m_inst[19:15];
      r2 = m_inst[24:20];
      hz = ex_mem_read && ex_rd != 0 &&
           ((ex_rd == r1 && uses_rs1(m_inst)) || (ex_rd == r2 && uses_rs2(m_inst)));
`ifndef REGFILE_BYPASS_EN
      hz = hz || (wb_en && wb_rd != 0 &&
           ((wb_rd == r1 && uses_rs1(m_inst)) || (wb_rd == r2 && uses_rs2(m_inst))));
`endif
      is_ec   = m_inst == ECALL;
      run     = m_st == SRun;
      e_ecall = m_st == SWait;
      e_stall = e_ecall || (run && !flush && (is_ec || hz));
      e_jmp   = run && !flush && !hz && (m_inst[6:0] == 7'b1101111 || m_inst[6:0] == 7'b1100111);
      e_ill   = run && !flush && fmt_of(m_inst[6:0]) == FX;
      e_imm   = imm_of(m_inst);
      e_base  = (m_inst[6:0] == 7'b1100111) ? rd_reg(r1) : m_pc;
      cmp("ex_pc", ex_pc, m_ex_pc);
      cmp("ex_rs1", ex_rs1, m_ex_rs1);
      cmp("ex_rs2", ex_rs2, m_ex_rs2);
      cmp("ex_imm", ex_imm, m_ex_imm);
      cmp("ex_rd_o", ex_rd_o, m_ex_rd);
      cmp("ex_ctrl", ex_ctrl, m_ex_ctrl);

      n_rf = m_rf;
      if (wb_en && wb_rd != 0) n_rf[wb_rd] = wb_data;
      n_st = m_st;
      n_cnt = m_cnt;
      if (run && is_ec && !flush) begin
        n_st = SWait; n_cnt = 0;
      end else if (m_st == SWait) begin
        if (io_done || (TMO != 0 && m_cnt + 1 == TMO)) begin
          n_st = SRes; n_cnt = 0;
        end else n_cnt = m_cnt + 1;
      end else if (m_st == SRes) n_st = SRun;

      n_pc = m_pc; n_inst = m_inst;
      n_ex_pc = '0; n_ex_rs1 = '0; n_ex_rs2 = '0; n_ex_imm = '0; n_ex_rd = '0; n_ex_ctrl = '0;
      if (flush || m_st == SRes) begin
        n_pc = '0; n_inst = NOP;
      end else if (!(m_st == SWait || (run && is_ec) || hz)) begin
        n_pc   = e_jmp ? 32'd0 : pc_in;
        n_inst = e_jmp ? NOP : inst_in;
        if (fmt_of(m_inst[6:0]) != FX) begin
          n_ex_pc   = m_pc;
          n_ex_rs1  = rd_reg(r1);
          n_ex_rs2  = rd_reg(r2);
          n_ex_imm  = e_imm;
          n_ex_ctrl = ctrl_of(m_inst);
          n_ex_rd   = n_ex_ctrl[11] ? m_inst[11:7] : 5'd0;
        end
      end
    end
    cmp("stall", stall, e_stall);
    cmp("ecall", ecall, e_ecall);
    cmp("jmp", jmp, e_jmp);
    cmp("illegal", illegal, e_ill);
    cmp("imm32", imm32, e_imm);
    cmp("jmp_base", jmp_base, e_base);
  end

  always @(posedge clk) begin
    m_pc <= n_pc; m_inst <= n_inst; m_st <= n_st; m_cnt <= n_cnt; m_rf <= n_rf;
    m_ex_pc <= n_ex_pc; m_ex_rs1 <= n_ex_rs1; m_ex_rs2 <= n_ex_rs2; m_ex_imm <= n_ex_imm;
    m_ex_rd <= n_ex_rd; m_ex_ctrl <= n_ex_ctrl;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] inst);
    pc_in = pc;
    inst_in = inst;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; ex_mem_read = 1'b0; ex_rd = '0; wb_en = 1'b0; wb_rd = '0;
    wb_data = '0; io_done = 1'b0;
    fetch(0, NOP);
    tick();
    #3 cmp("lit_rst_stall", stall, 0);
    cmp("lit_rst_ctrl", ex_ctrl, 0);
    tick();
    rst = 1'b1;
    fetch(0, ADDI5); tick();
    fetch(4, NOP);
    #3 cmp("lit_addi_imm32", imm32, 5);
    tick();
    #3 cmp("lit_addi_ex_imm", ex_imm, 5);
    cmp("lit_addi_rd", ex_rd_o, 1);
    cmp("lit_addi_rw_as", {ex_ctrl[11], ex_ctrl[8]}, 2'b11);
    cmp("lit_addi_stall", stall, 0);
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd7; tick();
    wb_rd = 5'd2; wb_data = 32'h100; tick();
    wb_en = 1'b0;
    fetch(32'h10, ADD6); tick();
    // Load-use: lw x5 in EX against add x6,x5,x1 in ID.
    ex_mem_read = 1'b1; ex_rd = 5'd5; fetch(32'h14, NOP);
    #3 cmp("lit_lu_stall", stall, 1);
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd0;
    #3 cmp("lit_lu_bubble", ex_ctrl, 0);
    cmp("lit_lu_release", stall, 0);
    tick();
    #3 cmp("lit_lu_rd", ex_rd_o, 6);
    cmp("lit_lu_rs2", ex_rs2, 7);
    fetch(32'h40, JALR8); tick();
    fetch(32'h44, ADDI5);
    #3 cmp("lit_jalr_jmp", jmp, 1);
    cmp("lit_jalr_base", jmp_base, 32'h100);
    cmp("lit_jalr_imm", imm32, 8);
    tick();
    fetch(32'h48, NOP);
    #3 cmp("lit_jalr_squash", imm32, 0);
    cmp("lit_jalr_exjump", {ex_ctrl[11], ex_ctrl[6]}, 2'b11);
    cmp("lit_jalr_rs1", ex_rs1, 32'h100);
    tick();
    fetch(32'h80, JAL16); tick();
    fetch(32'h84, NOP);
    #3 cmp("lit_jal_base", jmp_base, 32'h80);
    cmp("lit_jal_imm", imm32, 16);
    tick();
    fetch(32'h90, BEQM4); tick();
    fetch(32'h94, SWM12);
    #3 cmp("lit_b_imm", imm32, 32'hFFFF_FFFC);
    tick();
    fetch(32'h98, LUI7);
    #3 cmp("lit_s_imm", imm32, 32'hFFFF_FFF4);
    tick();
    fetch(32'h9C, BAD);
    #3 cmp("lit_u_imm", imm32, 32'hABCD_E000);
    tick();
    fetch(32'hA0, NOP);
    #3 cmp("lit_illegal", illegal, 1);
    tick();
    #3 cmp("lit_illegal_pulse", illegal, 0);
    cmp("lit_illegal_bubble", ex_ctrl, 0);
    fetch(32'hA4, ECALL); tick();
    fetch(32'hA8, NOP);
    #3 cmp("lit_ec_entry_stall", stall, 1);
    tick();
    for (int c = 0; c < 5; c++) begin
      #3 cmp("lit_ec_wait", {ecall, stall}, 2'b11);
      tick();
    end
    io_done = 1'b1;
    #3 cmp("lit_ec_done", ecall, 1);
    tick();
    io_done = 1'b0;
    #3 cmp("lit_ec_resume", {ecall, stall}, 2'b00);
    tick();
    #3 cmp("lit_ec_run", {ecall, stall}, 2'b00);
    fetch(32'hC0, ADD4); tick();
    wb_en = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD; fetch(32'hC4, NOP);
`ifdef REGFILE_BYPASS_EN
    #3 cmp("lit_byp_stall", stall, 0);
    tick();
    wb_en = 1'b0;
    #3 cmp("lit_byp_rs1", ex_rs1, 32'hDEAD);
`else
    #3 cmp("lit_byp_stall", stall, 1);
    tick();
    wb_en = 1'b0;
    #3 cmp("lit_byp_release", stall, 0);
    tick();
    #3 cmp("lit_byp_rs1", ex_rs1, 32'hDEAD);
`endif
    fetch(32'hD0, ADD6); tick();
    flush = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; fetch(32'hD4, ADDI5);
    #3 cmp("lit_fl_stall", stall, 0);
    cmp("lit_fl_illegal", illegal, 0);
    tick();
    flush = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; fetch(32'hD8, NOP);
    #3 cmp("lit_fl_ctrl", ex_ctrl, 0);
    cmp("lit_fl_expc", ex_pc, 0);
    cmp("lit_fl_ifid", {imm32, jmp_base}, 64'd0);
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
